sync_fifo_flagged: RTL and testbench
====================================

Name: sync_fifo_flagged

Overview:
- Parametrised synchronous FIFO: a register/SRAM storage array plus binary write and read pointers.
- Generalises the earlier fixed 4-entry FIFO to any power-of-two depth and any data width.
- Adds reset, full/empty/almost-full flags, an occupancy count, guarded writes and reads, and a read-valid strobe.
- Sits between burst producers and consumers in the datapath; everything runs in a single clock domain.

Parameters:
- ADR_W, 2, address width; depth DEPTH = 2**ADR_W entries (legal ADR_W >= 1).
- DATA_W, 288, data word width (72*4 packed lanes).
- AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL (legal 1..DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- wr_dt  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_dt  out  DATA_W  registered read data.
- rd_valid  out  1  rd_dt updated this cycle by an accepted read.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADR_W+1  current occupancy, 0..DEPTH.
- d_wadr  out  ADR_W  debug: write pointer, low bits.
- d_radr  out  ADR_W  debug: read pointer, low bits.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers cleared to 0; count=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_dt=0.
  - Storage contents are not cleared.
  - Reset has priority over wr_en and rd_en in the same cycle. Mid-operation reset discards all stored entries.
- Pointers:
  - Write and read pointers are ADR_W+1 bits; the MSB is the wrap bit.
  - The array is indexed by the low ADR_W bits. Pointers wrap modulo 2*DEPTH.
- Write accept:
  - Condition: wr_accept = wr_en & ~full.
  - On accept: mem[wptr] <= wr_dt, then wptr+1.
  - wr_en while full is dropped; storage and pointers are unchanged.
- Read accept:
  - Condition: rd_accept = rd_en & ~empty.
  - On accept: rd_dt <= mem[rptr], then rptr+1, and rd_valid=1 on the following cycle.
  - Latency is 1 cycle from rd_en to rd_dt/rd_valid.
  - rd_dt holds its last value when no read is accepted. rd_en while empty is ignored and rd_valid stays 0.
- Simultaneous wr_en & rd_en:
  - Not full and not empty: both accepted, count unchanged.
  - Empty: only the write is accepted; no bypass, the data becomes readable next cycle.
  - Full: only the read is accepted; the write is dropped, with no pass-through.
- Count update: count <= count + wr_accept - rd_accept.
- Flags: full, empty and almost_full are registered, derived from the next count; they are valid in the same cycle as count.
- Ordering: strict FIFO order is preserved across pointer wrap-around.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- When defined:
  - Adds outputs ovf_err and udf_err (1 bit each), reset to 0.
  - ovf_err sets on wr_en & full; udf_err sets on rd_en & empty.
  - Both stay set until rst.
- When undefined: the ports do not exist and no error logic is built. The dropped-request behaviour is identical in both builds.

Test Plan (ADR_W=2, DATA_W=8, AF_LEVEL=3):
- Reset check: assert rst for 2 cycles with wr_en=1 -> empty=1, full=0, count=0, rd_valid=0, rd_dt=0x00.
- Fill to full: write 0x11,0x22,0x33,0x44 -> count steps 1..4; almost_full rises when count=3; full=1 at count=4. A 5th write of 0x55 -> count stays 4 (ovf_err=1 if macro defined).
- Drain in order: read 4 times -> rd_dt=0x11,0x22,0x33,0x44, each with rd_valid=1 one cycle after rd_en. A 5th read -> rd_valid=0, rd_dt holds 0x44, empty=1 (udf_err=1 if macro defined).
- Simultaneous access:
  - At count=2, wr_en&rd_en with 0xA0 -> count stays 2, oldest word output.
  - When empty, wr_en&rd_en -> count=1, rd_valid=0.
  - When full, wr_en&rd_en -> count=3, written word dropped.
- Wrap-around: stream 10 words 0x01..0x0A with interleaved reads, never exceeding 3 in flight -> output sequence 0x01..0x0A exact; d_wadr/d_radr wrap 3->0.
- Reset mid-operation: at count=3, pulse rst -> next cycle count=0, empty=1. Then write 0xBB and read it -> rd_dt=0xBB.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// Parametrised single-clock FIFO with registered flags, occupancy count and read-valid strobe.
// Define FIFO_STICKY_ERR_EN to add sticky overflow/underflow error outputs.
module sync_fifo_flagged #(
  parameter int unsigned ADR_W    = 2,
  parameter int unsigned DATA_W   = 288,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_dt,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_dt,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic [ADR_W:0]    o_count,
  output logic [ADR_W-1:0]  o_d_wadr,
  output logic [ADR_W-1:0]  o_d_radr
`ifdef FIFO_STICKY_ERR_EN
  ,
  output logic              o_ovf_err,
  output logic              o_udf_err
`endif
);

  localparam int unsigned  DEPTH    = 2 ** ADR_W;
  localparam logic [ADR_W:0] LP_DEPTH = (ADR_W + 1)'(DEPTH);
  localparam logic [ADR_W:0] LP_AF    = (ADR_W + 1)'(AF_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADR_W:0]    r_wptr;
  logic [ADR_W:0]    r_rptr;
  logic [ADR_W:0]    r_count;
  logic [DATA_W-1:0] r_rd_dt;
  logic              r_rd_valid;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;

  logic              w_wr_accept;
  logic              w_rd_accept;
  logic [ADR_W:0]    w_count_d;

  // Reset outranks both requests, so neither side may touch storage during it.
  assign w_wr_accept = i_wr_en & ~r_full & ~i_rst;
  assign w_rd_accept = i_rd_en & ~r_empty & ~i_rst;

  always_comb begin
    w_count_d = r_count;
    case ({w_wr_accept, w_rd_accept})
      2'b10:   w_count_d = r_count + (ADR_W + 1)'(1);
      2'b01:   w_count_d = r_count - (ADR_W + 1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_mem[r_wptr[ADR_W-1:0]] <= i_wr_dt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_rd_dt       <= '0;
      r_rd_valid    <= 1'b0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wptr <= r_wptr + (ADR_W + 1)'(1);
      end
      if (w_rd_accept) begin
        r_rd_dt <= r_mem[r_rptr[ADR_W-1:0]];
        r_rptr  <= r_rptr + (ADR_W + 1)'(1);
      end
      r_rd_valid    <= w_rd_accept;
      r_count       <= w_count_d;
      r_full        <= (w_count_d == LP_DEPTH);
      r_empty       <= (w_count_d == '0);
      r_almost_full <= (w_count_d >= LP_AF);
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  logic r_ovf_err;
  logic r_udf_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (i_wr_en & r_full)  r_ovf_err <= 1'b1;
      if (i_rd_en & r_empty) r_udf_err <= 1'b1;
    end
  end

  assign o_ovf_err = r_ovf_err;
  assign o_udf_err = r_udf_err;
`endif

  assign o_rd_dt       = r_rd_dt;
  assign o_rd_valid    = r_rd_valid;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_almost_full = r_almost_full;
  assign o_count       = r_count;
  assign o_d_wadr      = r_wptr[ADR_W-1:0];
  assign o_d_radr      = r_rptr[ADR_W-1:0];

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged (ADR_W=2, DATA_W=8, AF_LEVEL=3) with a queue scoreboard.
// Honours FIFO_STICKY_ERR_EN when the same macro is defined for the design.
module tb_sync_fifo_flagged;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_dt;
  logic       rd_en;
  logic [7:0] rd_dt;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [2:0] count;
  logic [1:0] d_wadr;
  logic [1:0] d_radr;
`ifdef FIFO_STICKY_ERR_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  sync_fifo_flagged #(
    .ADR_W    (2),
    .DATA_W   (8),
    .AF_LEVEL (3)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (wr_en),
    .i_wr_dt       (wr_dt),
    .i_rd_en       (rd_en),
    .o_rd_dt       (rd_dt),
    .o_rd_valid    (rd_valid),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (almost_full),
    .o_count       (count),
    .o_d_wadr      (d_wadr),
    .o_d_radr      (d_radr)
`ifdef FIFO_STICKY_ERR_EN
    ,
    .o_ovf_err     (ovf_err),
    .o_udf_err     (udf_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] sb[$];
  int         m_count = 0;
  logic [7:0] m_last  = 8'h00;
  logic [1:0] m_wp    = 2'd0;
  logic [1:0] m_rp    = 2'd0;
  logic       m_ovf   = 1'b0;
  logic       m_udf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic exp_valid);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ".full"}, 32'(full), 32'(m_count == 4));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= 3));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    chk({tag, ".rd_dt"}, 32'(rd_dt), 32'(m_last));
    chk({tag, ".d_wadr"}, 32'(d_wadr), 32'(m_wp));
    chk({tag, ".d_radr"}, 32'(d_radr), 32'(m_rp));
`ifdef FIFO_STICKY_ERR_EN
    chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(m_ovf));
    chk({tag, ".udf_err"}, 32'(udf_err), 32'(m_udf));
`endif
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge, outputs checked likewise.
  task automatic cycle(input string tag, input logic wr, input logic [7:0] wd, input logic rd);
    logic wa;
    logic ra;
    wr_en = wr;
    wr_dt = wd;
    rd_en = rd;
    wa = wr && (m_count != 4);
    ra = rd && (m_count != 0);
    if (wr && m_count == 4) m_ovf = 1'b1;
    if (rd && m_count == 0) m_udf = 1'b1;
    if (wa) begin
      sb.push_back(wd);
      m_wp = m_wp + 2'd1;
    end
    if (ra) begin
      m_last = sb.pop_front();
      m_rp = m_rp + 2'd1;
    end
    m_count = m_count + int'(wa) - int'(ra);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag, ra);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    wr_en = 1'b1;
    wr_dt = 8'hFF;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b0;
    sb.delete();
    m_count = 0;
    m_last = 8'h00;
    m_wp = 2'd0;
    m_rp = 2'd0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state(tag, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_dt = 8'h00;
    rd_en = 1'b0;
    #1;

    // Reset held two cycles with a write request pending
    do_reset("reset", 2);

    // Fill to full, then an overflowing write
    cycle("fill1", 1'b1, 8'h11, 1'b0);
    cycle("fill2", 1'b1, 8'h22, 1'b0);
    cycle("fill3", 1'b1, 8'h33, 1'b0);
    cycle("fill4", 1'b1, 8'h44, 1'b0);
    cycle("ovf",   1'b1, 8'h55, 1'b0);

    // Drain in order, then an underflowing read
    cycle("drain1", 1'b0, 8'h00, 1'b1);
    cycle("drain2", 1'b0, 8'h00, 1'b1);
    cycle("drain3", 1'b0, 8'h00, 1'b1);
    cycle("drain4", 1'b0, 8'h00, 1'b1);
    cycle("udf",    1'b0, 8'h00, 1'b1);

    // Simultaneous access at count=2, when empty, and when full
    cycle("sim2_w1", 1'b1, 8'h31, 1'b0);
    cycle("sim2_w2", 1'b1, 8'h32, 1'b0);
    cycle("sim2_rw", 1'b1, 8'hA0, 1'b1);
    cycle("sim2_r1", 1'b0, 8'h00, 1'b1);
    cycle("sim2_r2", 1'b0, 8'h00, 1'b1);
    cycle("sim0_rw", 1'b1, 8'h5A, 1'b1);
    cycle("sim4_w1", 1'b1, 8'h61, 1'b0);
    cycle("sim4_w2", 1'b1, 8'h62, 1'b0);
    cycle("sim4_w3", 1'b1, 8'h63, 1'b0);
    cycle("sim4_rw", 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 3; i++) cycle("sim4_drain", 1'b0, 8'h00, 1'b1);

    // Wrap-around stream of 0x01..0x0A, at most 3 in flight
    cycle("wrap_w", 1'b1, 8'h01, 1'b0);
    cycle("wrap_w", 1'b1, 8'h02, 1'b0);
    for (int i = 3; i <= 10; i++) cycle("wrap_rw", 1'b1, 8'(i), 1'b1);
    cycle("wrap_r", 1'b0, 8'h00, 1'b1);
    cycle("wrap_r", 1'b0, 8'h00, 1'b1);
    chk("wrap.last_word", 32'(rd_dt), 32'h0A);

    // Reset mid-operation discards contents
    cycle("mid_w1", 1'b1, 8'hC1, 1'b0);
    cycle("mid_w2", 1'b1, 8'hC2, 1'b0);
    cycle("mid_w3", 1'b1, 8'hC3, 1'b0);
    do_reset("mid_reset", 1);
    cycle("post_w", 1'b1, 8'hBB, 1'b0);
    cycle("post_r", 1'b0, 8'h00, 1'b1);
    chk("post.rd_dt", 32'(rd_dt), 32'hBB);
    chk("post.sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
